uart_bus_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bus_ctrl.sv | 118 +++++++++++
 tb/tb_uart_bus_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: bus controller states and the register address decode
// used by both the register bank and the bus controller.
package uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        Write,
        TxPush,
        Read,
        RxPop,
        RxLatch,
        Ack
    } uart_ctrl_state_t;

    localparam logic [2:0] SIFIVE_TXDATA = 3'd0;
    localparam logic [2:0] SIFIVE_RXDATA = 3'd1;
    localparam logic [2:0] LITEX_DATA    = 3'd0;

    // True when a word address selects the given register
    function automatic logic addr_en(
        input logic [2:0] addr,
        input logic [2:0] reg_addr
    );
        return addr == reg_addr;
    endfunction

endpackage

// File: rtl/uart_bus_ctrl.sv
// UART bus controller: Wishbone-classic slave that sequences register-bank
// accesses so every TX push / RX pop completes atomically per transaction.
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter int LITEX_ARCH = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] addr_i,
    output logic       ack_o,
    output logic       bank_rd_en,
    output logic       bank_wr_en,
    output logic       rxdata_wr_en,
    output logic       tx_fifo_wr_en,
    output logic       rx_fifo_rd_en,
    input  logic       tx_fifo_full,
    input  logic       rx_fifo_empty,
    output logic       busy_o
);

    if (FIFO_DEPTH < 1) begin : g_depth_check
        $error("FIFO_DEPTH must be positive");
    end

    localparam logic [2:0] TxAddr =
        (LITEX_ARCH != 0) ? LITEX_DATA : SIFIVE_TXDATA;
    localparam logic [2:0] RxAddr =
        (LITEX_ARCH != 0) ? LITEX_DATA : SIFIVE_RXDATA;

    uart_ctrl_state_t state_q, state_d;
    logic [2:0]       a_q, a_d;
    logic             w_q, w_d;

    logic bank_wr_q;
    logic bank_rd_q;
    logic tx_push_q;
    logic rx_pop_q;
    logic rx_latch_q;
    logic in_ack_q;
    logic busy_q;

    logic req;
    logic is_tx;
    logic is_rx;

    assign req   = cyc_i & stb_i;
    assign is_tx = w_q & addr_en(a_q, TxAddr);
    assign is_rx = ~w_q & addr_en(a_q, RxAddr);

    // Next-state: FIFO status is looked at only in Write/Read
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        w_d     = w_q;
        unique case (state_q)
            Idle: begin
                if (req) begin
                    a_d     = addr_i;
                    w_d     = we_i;
                    state_d = we_i ? Write : Read;
                end
            end
            Write: begin
                state_d = (is_tx & ~tx_fifo_full) ? TxPush : Ack;
            end
            TxPush:  state_d = Ack;
            Read: begin
                state_d = (is_rx & ~rx_fifo_empty) ? RxPop : Ack;
            end
            RxPop:   state_d = RxLatch;
            RxLatch: state_d = Ack;
            Ack:     state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    // State, latched request and per-state strobes, all cleared by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= Idle;
            a_q        <= '0;
            w_q        <= 1'b0;
            bank_wr_q  <= 1'b0;
            bank_rd_q  <= 1'b0;
            tx_push_q  <= 1'b0;
            rx_pop_q   <= 1'b0;
            rx_latch_q <= 1'b0;
            in_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            w_q        <= w_d;
            bank_wr_q  <= (state_d == Write);
            bank_rd_q  <= (state_d == Read);
            tx_push_q  <= (state_d == TxPush);
            rx_pop_q   <= (state_d == RxPop);
            rx_latch_q <= (state_d == RxLatch);
            in_ack_q   <= (state_d == Ack);
            busy_q     <= (state_d != Idle);
        end
    end

    // Ack is withheld if the master abandoned the cycle
    assign ack_o         = in_ack_q & cyc_i & stb_i;
    assign bank_wr_en    = bank_wr_q;
    assign bank_rd_en    = bank_rd_q;
    assign tx_fifo_wr_en = tx_push_q;
    assign rx_fifo_rd_en = rx_pop_q;
    assign rxdata_wr_en  = rx_latch_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: directed test-plan cases plus
// randomized transactions on a SiFive and a LiteX instance.
module tb_uart_bus_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cyc_i, stb_i, we_i;
    logic [2:0] addr_i;
    logic       tx_fifo_full, rx_fifo_empty;

    logic [1:0] ack, rd, wr, latch, push, pop, busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    uart_bus_ctrl #(.LITEX_ARCH(0), .FIFO_DEPTH(8)) u_sf (
        .clock(clock), .reset_n(reset_n),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .addr_i(addr_i),
        .ack_o(ack[0]), .bank_rd_en(rd[0]), .bank_wr_en(wr[0]),
        .rxdata_wr_en(latch[0]), .tx_fifo_wr_en(push[0]),
        .rx_fifo_rd_en(pop[0]), .tx_fifo_full(tx_fifo_full),
        .rx_fifo_empty(rx_fifo_empty), .busy_o(busy[0])
    );

    uart_bus_ctrl #(.LITEX_ARCH(1), .FIFO_DEPTH(8)) u_lx (
        .clock(clock), .reset_n(reset_n),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .addr_i(addr_i),
        .ack_o(ack[1]), .bank_rd_en(rd[1]), .bank_wr_en(wr[1]),
        .rxdata_wr_en(latch[1]), .tx_fifo_wr_en(push[1]),
        .rx_fifo_rd_en(pop[1]), .tx_fifo_full(tx_fifo_full),
        .rx_fifo_empty(rx_fifo_empty), .busy_o(busy[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs(input int sel);
        return int'({ack[sel], rd[sel], wr[sel], latch[sel],
                     push[sel], pop[sel], busy[sel]});
    endfunction

    // One bus transaction; drop_at>0 drops stb_i after that cycle
    task automatic run_txn(input int sel, input bit we, input int addr,
                           input bit full, input bit empty,
                           input int drop_at, input string tag);
        int wr_n = 0, wr_c = 0, rd_n = 0, rd_c = 0;
        int push_n = 0, push_c = 0, pop_n = 0, pop_c = 0;
        int latch_n = 0, latch_c = 0, ack_n = 0, ack_c = 0, busy_n = 0;
        bit is_tx, is_rx, do_push, do_pop;
        int e_ack;
        @(negedge clock);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i = we;
        addr_i = 3'(addr);
        tx_fifo_full = full;
        rx_fifo_empty = empty;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (wr[sel])    begin wr_n++;    wr_c = k;    end
            if (rd[sel])    begin rd_n++;    rd_c = k;    end
            if (push[sel])  begin push_n++;  push_c = k;  end
            if (pop[sel])   begin pop_n++;   pop_c = k;   end
            if (latch[sel]) begin latch_n++; latch_c = k; end
            if (ack[sel])   begin ack_n++;   ack_c = k;   end
            if (busy[sel]) busy_n++;
            if (ack[sel]) begin
                cyc_i = 1'b0;
                stb_i = 1'b0;
            end else if (k == drop_at) begin
                stb_i = 1'b0;
            end
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        // Reference: address map and latency rules
        is_tx = (sel == 1) ? (addr == 0) : (addr == 0);
        is_rx = (sel == 1) ? (addr == 0) : (addr == 1);
        do_push = we && is_tx && !full;
        do_pop = !we && is_rx && !empty;
        e_ack = do_push ? 3 : (do_pop ? 4 : 2);
        check({tag, ".wr_n"}, wr_n, we ? 1 : 0);
        check({tag, ".wr_c"}, wr_c, we ? 1 : 0);
        check({tag, ".rd_n"}, rd_n, we ? 0 : 1);
        check({tag, ".rd_c"}, rd_c, we ? 0 : 1);
        check({tag, ".push_n"}, push_n, do_push ? 1 : 0);
        check({tag, ".push_c"}, push_c, do_push ? 2 : 0);
        check({tag, ".pop_n"}, pop_n, do_pop ? 1 : 0);
        check({tag, ".pop_c"}, pop_c, do_pop ? 2 : 0);
        check({tag, ".latch_n"}, latch_n, do_pop ? 1 : 0);
        check({tag, ".latch_c"}, latch_c, do_pop ? 3 : 0);
        check({tag, ".busy_n"}, busy_n, e_ack);
        if (drop_at > 0 && drop_at < e_ack) begin
            check({tag, ".ack_n"}, ack_n, 0);
        end else begin
            check({tag, ".ack_n"}, ack_n, 1);
            check({tag, ".ack_c"}, ack_c, e_ack);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i = 1'b1;
        addr_i = 3'd0;
        tx_fifo_full = 1'b0;
        rx_fifo_empty = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_sf", all_outs(0), 0);
        check("reset_lx", all_outs(1), 0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_sf", all_outs(0), 0);

        run_txn(0, 1'b1, 0, 1'b0, 1'b0, 0, "sf_tx_push");
        run_txn(0, 1'b1, 0, 1'b1, 1'b0, 0, "sf_tx_full");
        run_txn(0, 1'b0, 1, 1'b0, 1'b0, 0, "sf_rx_pop");
        run_txn(0, 1'b0, 1, 1'b0, 1'b1, 0, "sf_rx_empty");
        run_txn(1, 1'b0, 0, 1'b0, 1'b0, 0, "lx_rx_pop");
        run_txn(1, 1'b1, 0, 1'b0, 1'b0, 0, "lx_tx_push");
        run_txn(0, 1'b0, 1, 1'b0, 1'b0, 2, "sf_abort");

        // Reset asserted while TxPush strobe is high
        @(negedge clock);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i = 1'b1;
        addr_i = 3'd0;
        tx_fifo_full = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_push", int'(push[0]), 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_sf", all_outs(0), 0);
        check("mid_rst_lx", all_outs(1), 0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_txn(0, 1'b1, 3, 1'b0, 1'b0, 0, "post_rst_wr3");

        for (int n = 0; n < 40; n++) begin
            int sel, addr, drop;
            bit we, full, empty;
            sel = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 3));
            full = 1'($urandom_range(0, 1));
            empty = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) : 0;
            run_txn(sel, we, addr, full, empty, drop,
                    $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
